// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: time-shares one combinational ALU between two requesters.
// Requester 0 is the main datapath and requester 1 is an auxiliary unit.
// One operation is in flight at a time: IDLE (grant) -> EXEC (ALU evaluates
// the registered operands) -> RESP (result held until the granted requester
// accepts it). When both requesters are valid, the grant alternates between them.
module alu_share_arbiter (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [1:0]  Req_Valid,
  output logic [1:0]  Req_Ready,
  input  logic [31:0] Req0_A,
  input  logic [31:0] Req0_B,
  input  logic [3:0]  Req0_Ctrl,
  input  logic [31:0] Req1_A,
  input  logic [31:0] Req1_B,
  input  logic [3:0]  Req1_Ctrl,
  output logic [1:0]  Resp_Valid,
  input  logic [1:0]  Resp_Ready,
  output logic [31:0] Resp_Result,
  output logic        Resp_Zero,
  output logic        Resp_Err,
  output logic [31:0] Alu_A,
  output logic [31:0] Alu_B,
  output logic [3:0]  Alu_Ctrl,
  input  logic [31:0] Alu_Result,
  input  logic        Alu_Zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;
  logic   grant_reg;       // requester that owns the in-flight operation
  logic   last_grant_reg;  // most recent grant; the other requester wins a tie
  logic   arb_sel;         // requester picked by the arbiter this cycle
  logic   ctrl_legal;

  // Decode the registered control code against the ALU's supported operations.
  always_comb begin
    ctrl_legal = 1'b0;
    case (Alu_Ctrl)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: ctrl_legal = 1'b1;
      default: ctrl_legal = 1'b0;
    endcase
  end

  // Arbitration, next-state logic and the handshake outputs.
  always_comb begin
    state_next = state_reg;
    Req_Ready  = 2'b00;
    Resp_Valid = 2'b00;
    arb_sel    = 1'b0;
    case (Req_Valid)
      2'b01:   arb_sel = 1'b0;
      2'b10:   arb_sel = 1'b1;
      2'b11:   arb_sel = ~last_grant_reg;
      default: arb_sel = 1'b0;
    endcase
    case (state_reg)
      IDLE: begin
        if (|Req_Valid) begin
          Req_Ready[arb_sel] = 1'b1;
          state_next         = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        Resp_Valid[grant_reg] = 1'b1;
        if (Resp_Ready[grant_reg]) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, operand capture and the response register.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_reg      <= IDLE;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      Alu_A          <= 32'd0;
      Alu_B          <= 32'd0;
      Alu_Ctrl       <= 4'd0;
      Resp_Result    <= 32'd0;
      Resp_Zero      <= 1'b0;
      Resp_Err       <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (|Req_Valid) begin
            grant_reg      <= arb_sel;
            last_grant_reg <= arb_sel;
            Alu_A          <= arb_sel ? Req1_A    : Req0_A;
            Alu_B          <= arb_sel ? Req1_B    : Req0_B;
            Alu_Ctrl       <= arb_sel ? Req1_Ctrl : Req0_Ctrl;
          end
        end
        EXEC: begin
          // Zero reports operand equality, so it is kept even for illegal codes.
          Resp_Result <= ctrl_legal ? Alu_Result : 32'd0;
          Resp_Zero   <= Alu_Zero;
          Resp_Err    <= ~ctrl_legal;
        end
        RESP: begin
          if (Resp_Ready[grant_reg]) begin
            Resp_Result <= 32'd0;
            Resp_Err    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: table of single operations plus sequences
// for contention, back-pressure and reset during an operation.
module tb_alu_share_arbiter;

  logic        Clk;
  logic        Rst_n;
  logic [1:0]  Req_Valid;
  logic [1:0]  Req_Ready;
  logic [31:0] Req0_A, Req0_B, Req1_A, Req1_B;
  logic [3:0]  Req0_Ctrl, Req1_Ctrl;
  logic [1:0]  Resp_Valid;
  logic [1:0]  Resp_Ready;
  logic [31:0] Resp_Result;
  logic        Resp_Zero;
  logic        Resp_Err;
  logic [31:0] Alu_A, Alu_B;
  logic [3:0]  Alu_Ctrl;
  logic [31:0] Alu_Result;
  logic        Alu_Zero;

  int n_cmp = 0;
  int n_bad = 0;

  alu_share_arbiter dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .Req_Valid(Req_Valid), .Req_Ready(Req_Ready),
    .Req0_A(Req0_A), .Req0_B(Req0_B), .Req0_Ctrl(Req0_Ctrl),
    .Req1_A(Req1_A), .Req1_B(Req1_B), .Req1_Ctrl(Req1_Ctrl),
    .Resp_Valid(Resp_Valid), .Resp_Ready(Resp_Ready),
    .Resp_Result(Resp_Result), .Resp_Zero(Resp_Zero), .Resp_Err(Resp_Err),
    .Alu_A(Alu_A), .Alu_B(Alu_B), .Alu_Ctrl(Alu_Ctrl),
    .Alu_Result(Alu_Result), .Alu_Zero(Alu_Zero)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Behavioural ALU; unknown codes give a non-zero pattern the DUT must suppress.
  always_comb begin
    case (Alu_Ctrl)
      4'b0000: Alu_Result = Alu_A & Alu_B;
      4'b0001: Alu_Result = Alu_A | Alu_B;
      4'b0010: Alu_Result = Alu_A + Alu_B;
      4'b0110: Alu_Result = Alu_A - Alu_B;
      4'b0111: Alu_Result = ($signed(Alu_A) < $signed(Alu_B)) ? 32'd1 : 32'd0;
      4'b1100: Alu_Result = ~(Alu_A | Alu_B);
      default: Alu_Result = 32'hDEADBEEF;
    endcase
    Alu_Zero = (Alu_A == Alu_B);
  end

  typedef struct {
    bit          req;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_req(input bit r, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] c);
    if (r) begin
      Req1_A = a; Req1_B = b; Req1_Ctrl = c;
    end else begin
      Req0_A = a; Req0_B = b; Req0_Ctrl = c;
    end
  endtask

  // Full single operation from the current negedge (block idle) back to idle.
  task automatic run_op(input vec_t v, input int idx);
    logic [1:0] oh;
    oh = v.req ? 2'b10 : 2'b01;
    drive_req(v.req, v.a, v.b, v.ctrl);
    drive_req(~v.req, 32'h12345678, 32'h0badf00d, 4'b0001);
    Req_Valid  = oh;
    Resp_Ready = oh;
    #1;
    chk($sformatf("v%0d req_ready", idx), {30'd0, Req_Ready}, {30'd0, oh});
    @(posedge Clk); @(negedge Clk);
    Req_Valid = 2'b00;
    chk($sformatf("v%0d alu_a", idx), Alu_A, v.a);
    chk($sformatf("v%0d alu_b", idx), Alu_B, v.b);
    chk($sformatf("v%0d alu_ctrl", idx), {28'd0, Alu_Ctrl}, {28'd0, v.ctrl});
    chk($sformatf("v%0d exec_resp_valid", idx), {30'd0, Resp_Valid}, 32'd0);
    @(posedge Clk); @(negedge Clk);
    chk($sformatf("v%0d resp_valid", idx), {30'd0, Resp_Valid}, {30'd0, oh});
    chk($sformatf("v%0d result", idx), Resp_Result, v.res);
    chk($sformatf("v%0d zero", idx), {31'd0, Resp_Zero}, {31'd0, v.zero});
    chk($sformatf("v%0d err", idx), {31'd0, Resp_Err}, {31'd0, v.err});
    $display("op %0d: req%0d a=%h b=%h ctrl=%b -> result=%h zero=%0b err=%0b",
             idx, v.req, v.a, v.b, v.ctrl, Resp_Result, Resp_Zero, Resp_Err);
    @(posedge Clk); @(negedge Clk);
    chk($sformatf("v%0d idle_resp_valid", idx), {30'd0, Resp_Valid}, 32'd0);
    chk($sformatf("v%0d idle_result", idx), Resp_Result, 32'd0);
    chk($sformatf("v%0d idle_err", idx), {31'd0, Resp_Err}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'd50,         32'd20,         4'b0010, 32'd70,         1'b0, 1'b0};
    vecs[1]  = '{1'b1, 32'd50,         32'd55,         4'b0111, 32'd1,          1'b0, 1'b0};
    vecs[2]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFF9,   4'b0110, 32'd0,          1'b1, 1'b0};
    vecs[3]  = '{1'b0, 32'd1,          32'd1,          4'b1111, 32'd0,          1'b1, 1'b1};
    vecs[4]  = '{1'b0, 32'd5,          32'd3,          4'b0000, 32'd1,          1'b0, 1'b0};
    vecs[5]  = '{1'b1, 32'd5,          32'd3,          4'b0001, 32'd7,          1'b0, 1'b0};
    vecs[6]  = '{1'b0, 32'd0,          32'd0,          4'b1100, 32'hFFFFFFFF,   1'b1, 1'b0};
    vecs[7]  = '{1'b1, 32'hFFFFFFFF,   32'd1,          4'b0010, 32'd0,          1'b0, 1'b0};
    vecs[8]  = '{1'b0, 32'hFFFFFFFB,   32'd3,          4'b0111, 32'd1,          1'b0, 1'b0};
    vecs[9]  = '{1'b0, 32'd3,          32'hFFFFFFFB,   4'b0111, 32'd0,          1'b0, 1'b0};
    vecs[10] = '{1'b1, 32'h7FFFFFFF,   32'd1,          4'b0010, 32'h80000000,   1'b0, 1'b0};
    vecs[11] = '{1'b0, 32'd10,         32'd3,          4'b0110, 32'd7,          1'b0, 1'b0};
    vecs[12] = '{1'b1, 32'd4,          32'd4,          4'b1010, 32'd0,          1'b1, 1'b1};

    Rst_n = 1'b0; Req_Valid = 2'b00; Resp_Ready = 2'b00;
    Req0_A = '0; Req0_B = '0; Req0_Ctrl = '0;
    Req1_A = '0; Req1_B = '0; Req1_Ctrl = '0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst req_ready", {30'd0, Req_Ready}, 32'd0);
    chk("rst resp_valid", {30'd0, Resp_Valid}, 32'd0);
    chk("rst result", Resp_Result, 32'd0);
    chk("rst zero_err", {30'd0, Resp_Zero, Resp_Err}, 32'd0);
    chk("rst alu_a", Alu_A, 32'd0);
    chk("rst alu_b", Alu_B, 32'd0);
    chk("rst alu_ctrl", {28'd0, Alu_Ctrl}, 32'd0);
    Rst_n = 1'b1;

    // Table of single operations.
    for (int i = 0; i < 13; i++) run_op(vecs[i], i);

    // Contention straight after reset: grants alternate 0,1,0,1.
    Rst_n = 1'b0;
    @(posedge Clk); @(negedge Clk);
    Rst_n = 1'b1;
    drive_req(1'b0, 32'd3, 32'd6, 4'b0000);
    drive_req(1'b1, 32'd3, 32'd6, 4'b0001);
    Req_Valid = 2'b11; Resp_Ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("cont%0d grant", i), {30'd0, Req_Ready}, (i % 2) ? 32'd2 : 32'd1);
      @(posedge Clk); @(negedge Clk);
      chk($sformatf("cont%0d exec_ready", i), {30'd0, Req_Ready}, 32'd0);
      @(posedge Clk); @(negedge Clk);
      chk($sformatf("cont%0d resp_valid", i), {30'd0, Resp_Valid}, (i % 2) ? 32'd2 : 32'd1);
      chk($sformatf("cont%0d result", i), Resp_Result, (i % 2) ? 32'd7 : 32'd2);
      $display("contention op %0d: resp_valid=%b result=%h", i, Resp_Valid, Resp_Result);
      @(posedge Clk); @(negedge Clk);
    end

    // Back-pressure: last grant was 1, so requester 0 wins; hold its response.
    drive_req(1'b0, 32'd100, 32'd23, 4'b0010);
    Resp_Ready = 2'b00;
    #1;
    chk("bp grant", {30'd0, Req_Ready}, 32'd1);
    @(posedge Clk); @(negedge Clk);
    @(posedge Clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk($sformatf("bp%0d resp_valid", i), {30'd0, Resp_Valid}, 32'd1);
      chk($sformatf("bp%0d result", i), Resp_Result, 32'd123);
      chk($sformatf("bp%0d req_ready", i), {30'd0, Req_Ready}, 32'd0);
      @(posedge Clk);
    end
    @(negedge Clk);
    Resp_Ready = 2'b10;  // wrong requester's ready must be ignored
    #1;
    @(posedge Clk); @(negedge Clk);
    chk("bp ignore_other_ready", {30'd0, Resp_Valid}, 32'd1);
    Resp_Ready = 2'b01;
    #1;
    chk("bp release_ready_same_cycle", {30'd0, Req_Ready}, 32'd0);
    @(posedge Clk); @(negedge Clk);
    chk("bp done resp_valid", {30'd0, Resp_Valid}, 32'd0);
    chk("bp next grant", {30'd0, Req_Ready}, 32'd2);
    $display("back-pressure op: result held at 123, next grant to req1");
    @(posedge Clk); @(negedge Clk);
    Req_Valid = 2'b00; Resp_Ready = 2'b11;
    @(posedge Clk); @(negedge Clk);
    chk("bp req1 resp_valid", {30'd0, Resp_Valid}, 32'd2);
    chk("bp req1 result", Resp_Result, 32'd7);
    @(posedge Clk); @(negedge Clk);

    // Reset during EXEC drops the operation.
    drive_req(1'b0, 32'd9, 32'd9, 4'b0010);
    Req_Valid = 2'b01;
    @(posedge Clk); @(negedge Clk);
    Req_Valid = 2'b00; Rst_n = 1'b0;
    @(posedge Clk); @(negedge Clk);
    chk("midrst resp_valid", {30'd0, Resp_Valid}, 32'd0);
    chk("midrst req_ready", {30'd0, Req_Ready}, 32'd0);
    chk("midrst result", Resp_Result, 32'd0);
    chk("midrst zero_err", {30'd0, Resp_Zero, Resp_Err}, 32'd0);
    chk("midrst alu_a", Alu_A, 32'd0);
    chk("midrst alu_ctrl", {28'd0, Alu_Ctrl}, 32'd0);
    Rst_n = 1'b1;
    @(posedge Clk); @(negedge Clk);
    chk("midrst no_resp", {30'd0, Resp_Valid}, 32'd0);
    $display("reset mid-op: operation dropped");
    run_op('{1'b1, 32'd20, 32'd5, 4'b0110, 32'd15, 1'b0, 1'b0}, 13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
